// File: rtl/morse_letter_decoder_pkg.sv
// Shared Morse definitions: symbol codes, decoder states, ASCII constants.
// The upstream dit/dah counter uses the same symbol codes.
package morse_letter_decoder_pkg;

  typedef enum logic [2:0] {
    SYM_NONE       = 3'd0,
    SYM_DIT        = 3'd1,
    SYM_DAH        = 3'd2,
    SYM_LETTER_GAP = 3'd3,
    SYM_WORD_GAP   = 3'd4
  } sym_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT_SPACE
  } state_e;

  localparam logic [7:0]  ASCII_SPACE          = 8'h20;
  localparam logic [7:0]  UNKNOWN_CHAR_DEFAULT = 8'h3F;
  localparam int unsigned MAX_SYMS_DEFAULT     = 5;

  // Codes 5-7 carry no symbol and behave like NONE.
  function automatic sym_e decode_sym(input logic [2:0] code);
    return (code > 3'd4) ? SYM_NONE : sym_e'(code);
  endfunction

endpackage

// File: rtl/morse_letter_decoder_if.sv
// Symbol input and strobed character output of the Morse letter decoder.
interface morse_letter_decoder_if;
  logic [2:0] ditsdahs;
  logic [7:0] char_data;
  logic       char_valid;
  logic       sym_error;

  modport master (output ditsdahs, input char_data, input char_valid, input sym_error);
  modport slave  (input ditsdahs, output char_data, output char_valid, output sym_error);
endinterface

// File: rtl/morse_letter_decoder_lookup.sv
// Combinational Morse ROM: (len, pattern) -> ASCII, bit i = symbol i, 1 = DAH.
// Pattern bits at index >= len are masked off before matching.
module morse_letter_decoder_lookup #(
  parameter int unsigned MAX_SYMS = 5,
  parameter int unsigned LEN_W    = $clog2(MAX_SYMS + 1)
) (
  input  logic [LEN_W-1:0]    len_i,
  input  logic [MAX_SYMS-1:0] pattern_i,
  output logic [7:0]          ascii_o,
  output logic                hit_o
);
  localparam int unsigned PW = (MAX_SYMS > 5) ? MAX_SYMS : 5;

  logic [PW-1:0] pat_wide;
  logic [4:0]    pat5;
  logic [12:0]   key;

  always_comb begin
    pat_wide = PW'(pattern_i);
    pat5     = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < 32'(len_i)) pat5[i] = pat_wide[i];
    end
    key     = {8'(len_i), pat5};
    ascii_o = '0;
    hit_o   = 1'b1;
    case (key)
      {8'd2, 5'b00010}: ascii_o = "A";
      {8'd4, 5'b00001}: ascii_o = "B";
      {8'd4, 5'b00101}: ascii_o = "C";
      {8'd3, 5'b00001}: ascii_o = "D";
      {8'd1, 5'b00000}: ascii_o = "E";
      {8'd4, 5'b00100}: ascii_o = "F";
      {8'd3, 5'b00011}: ascii_o = "G";
      {8'd4, 5'b00000}: ascii_o = "H";
      {8'd2, 5'b00000}: ascii_o = "I";
      {8'd4, 5'b01110}: ascii_o = "J";
      {8'd3, 5'b00101}: ascii_o = "K";
      {8'd4, 5'b00010}: ascii_o = "L";
      {8'd2, 5'b00011}: ascii_o = "M";
      {8'd2, 5'b00001}: ascii_o = "N";
      {8'd3, 5'b00111}: ascii_o = "O";
      {8'd4, 5'b00110}: ascii_o = "P";
      {8'd4, 5'b01011}: ascii_o = "Q";
      {8'd3, 5'b00010}: ascii_o = "R";
      {8'd3, 5'b00000}: ascii_o = "S";
      {8'd1, 5'b00001}: ascii_o = "T";
      {8'd3, 5'b00100}: ascii_o = "U";
      {8'd4, 5'b01000}: ascii_o = "V";
      {8'd3, 5'b00110}: ascii_o = "W";
      {8'd4, 5'b01001}: ascii_o = "X";
      {8'd4, 5'b01101}: ascii_o = "Y";
      {8'd4, 5'b00011}: ascii_o = "Z";
      {8'd5, 5'b11111}: ascii_o = "0";
      {8'd5, 5'b11110}: ascii_o = "1";
      {8'd5, 5'b11100}: ascii_o = "2";
      {8'd5, 5'b11000}: ascii_o = "3";
      {8'd5, 5'b10000}: ascii_o = "4";
      {8'd5, 5'b00000}: ascii_o = "5";
      {8'd5, 5'b00001}: ascii_o = "6";
      {8'd5, 5'b00011}: ascii_o = "7";
      {8'd5, 5'b00111}: ascii_o = "8";
      {8'd5, 5'b01111}: ascii_o = "9";
      default:          hit_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_letter_decoder.sv
// Accumulates DIT/DAH symbols and emits one-cycle ASCII strobes on letter/word gaps,
// including a single space per word gap.
module morse_letter_decoder
  import morse_letter_decoder_pkg::*;
#(
  parameter int unsigned MAX_SYMS     = MAX_SYMS_DEFAULT,
  parameter logic [7:0]  UNKNOWN_CHAR = UNKNOWN_CHAR_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  morse_letter_decoder_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_SYMS + 1);

  state_e              state_q, state_d;
  sym_e                prev_q, prev_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [MAX_SYMS-1:0] pat_q, pat_d;
  logic                ovf_q, ovf_d;
  logic                lws_q, lws_d;
  logic [7:0]          char_q, char_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  sym_e       sym;
  logic       sym_event;
  logic [7:0] lk_ascii;
  logic       lk_hit;

  assign sym       = decode_sym(bus.ditsdahs);
  assign sym_event = (sym != SYM_NONE) && (sym != prev_q);

  morse_letter_decoder_lookup #(
    .MAX_SYMS (MAX_SYMS),
    .LEN_W    (LEN_W)
  ) u_lookup (
    .len_i     (len_q),
    .pattern_i (pat_q),
    .ascii_o   (lk_ascii),
    .hit_o     (lk_hit)
  );

  always_comb begin
    state_d = state_q;
    prev_d  = sym;
    len_d   = len_q;
    pat_d   = pat_q;
    ovf_d   = ovf_q;
    lws_d   = lws_q;
    char_d  = char_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    // The pending space goes out first; a symbol event this cycle then
    // overlays onto the already-empty buffer so nothing is dropped.
    if (state_q == ST_EMIT_SPACE) begin
      char_d  = ASCII_SPACE;
      valid_d = 1'b1;
      lws_d   = 1'b1;
      state_d = ST_IDLE;
    end

    if (sym_event) begin
      case (sym)
        SYM_DIT, SYM_DAH: begin
          if (32'(len_q) < MAX_SYMS) begin
            pat_d[len_q] = (sym == SYM_DAH);
            len_d        = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          state_d = ST_COLLECT;
        end
        SYM_LETTER_GAP, SYM_WORD_GAP: begin
          if (state_q == ST_COLLECT) begin
            char_d  = (ovf_q || !lk_hit) ? UNKNOWN_CHAR : lk_ascii;
            err_d   = ovf_q || !lk_hit;
            valid_d = 1'b1;
            len_d   = '0;
            pat_d   = '0;
            ovf_d   = 1'b0;
            lws_d   = 1'b0;
            state_d = (sym == SYM_WORD_GAP) ? ST_EMIT_SPACE : ST_IDLE;
          end else if (sym == SYM_WORD_GAP && state_q == ST_IDLE && !lws_q) begin
            char_d  = ASCII_SPACE;
            valid_d = 1'b1;
            lws_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prev_q  <= SYM_NONE;
      len_q   <= '0;
      pat_q   <= '0;
      ovf_q   <= 1'b0;
      lws_q   <= 1'b1;
      char_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      ovf_q   <= ovf_d;
      lws_q   <= lws_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.char_data  = char_q;
  assign bus.char_valid = valid_q;
  assign bus.sym_error  = err_q;

endmodule
